// File: rtl/arb_matrix_ctrl.sv
// Lock-and-hold controller for an external combinational matrix arbiter.
// Captures one grant, holds it until the granted requester's last beat transfers, then demotes it.
module arb_matrix_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         v_req,
    input  logic [WIDTH-1:0]         v_last,
    input  logic                     gnt_ready,
    output logic [WIDTH-1:0]         vv_matrix [WIDTH],
    output logic [WIDTH-1:0]         v_vld,
    input  logic [WIDTH-1:0]         v_grant,
    output logic [WIDTH-1:0]         v_grant_q,
    output logic                     grant_valid,
    output logic [$clog2(WIDTH)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   matrix_q [WIDTH];
    logic [WIDTH-1:0]   matrix_d [WIDTH];
    logic [IDX_W-1:0]   grant_enc;
    logic               last_xfer;

    // One-hot to binary index of the arbiter's grant.
    always_comb begin
        grant_enc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v_grant[i]) begin
                grant_enc = IDX_W'(i);
            end
        end
    end

    // Only the locked requester's last flag can end the transfer.
    assign last_xfer = gnt_ready && (|(v_last & gnt_q));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        matrix_d = matrix_q;
        v_vld    = '0;
        case (state_q)
            IDLE: begin
                v_vld = v_req;
                gnt_d = '0;
                idx_d = '0;
                if ((|v_req) && (|v_grant)) begin
                    gnt_d   = v_grant;
                    idx_d   = grant_enc;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    // Winner blocks by everyone; nobody is blocked by it any more.
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (gnt_q[i]) begin
                            matrix_d[i] = ~(WIDTH'(1) << i);
                        end else begin
                            matrix_d[i] = matrix_q[i] & ~gnt_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                matrix_q[i] <= (WIDTH'(1) << i) - WIDTH'(1);
            end
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            matrix_q <= matrix_d;
        end
    end

    assign vv_matrix   = matrix_q;
    assign v_grant_q   = gnt_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == BUSY);

endmodule

// File: doc/arb_matrix_ctrl.md
ARB_MATRIX_CTRL -- requirements
Module: arb_matrix_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of requesters (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port v_req, input, WIDTH, the per-requester request level.
REQ-005 SHALL have port v_last, input, WIDTH, per-requester flag marking the current beat as the final beat of its transfer.
REQ-006 SHALL have port gnt_ready, input, 1, downstream acceptance of the current granted beat.
REQ-007 SHALL have port vv_matrix, output, WIDTH x WIDTH (unpacked array of WIDTH rows), the priority matrix driven to the combinational matrix arbiter; row i bit j = 1 means requester j blocks requester i.
REQ-008 SHALL have port v_vld, output, WIDTH, the request vector driven to the arbiter.
REQ-009 SHALL have port v_grant, input, WIDTH, the one-hot grant returned combinationally by the arbiter.
REQ-010 SHALL have port v_grant_q, output, WIDTH, the registered one-hot locked grant.
REQ-011 SHALL have port grant_valid, output, 1, high while a grant is held.
REQ-012 SHALL have port grant_idx, output, $clog2(WIDTH), the binary index of v_grant_q.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-014 SHALL drive v_vld = v_req in IDLE and v_vld = 0 in BUSY.
REQ-015 SHALL, in IDLE with |v_req = 1, register v_grant into v_grant_q and enter BUSY on the same edge; grant_valid rises one cycle after the request is sampled.
REQ-016 SHALL, in IDLE with v_req = 0, remain in IDLE with v_grant_q = 0.
REQ-017 SHALL treat a beat as transferred in a cycle with grant_valid = 1 and gnt_ready = 1.
REQ-018 SHALL hold v_grant_q, grant_idx and vv_matrix constant in BUSY until a transferred beat has v_last[grant_idx] = 1, regardless of changes to v_req, including deassertion by the granted requester.
REQ-019 SHALL, on the transferred last beat of granted requester k, update the matrix on that edge: row k, all bits j != k, set to 1; column k, all rows j != k, cleared to 0; all other bits unchanged. k becomes lowest priority.
REQ-020 SHALL, on that same edge, clear v_grant_q, drop grant_valid and return to IDLE; one IDLE cycle always separates consecutive grants.
REQ-021 SHALL NOT update the matrix when v_last[k] = 1 and gnt_ready = 0.
REQ-022 SHALL ignore v_last bits of non-granted requesters.
REQ-023 SHALL keep every diagonal bit vv_matrix[i][i] at 0 at all times.
REQ-024 SHALL keep the matrix antisymmetric: for every i != j, exactly one of [i][j] and [j][i] is 1.
REQ-025 SHALL, if the arbiter returns v_grant = 0 in IDLE while |v_req = 1, remain in IDLE with no state change.

Reset
REQ-026 SHALL, with rst = 1, drive on the next edge: FSM = IDLE, v_grant_q = 0, grant_valid = 0, grant_idx = 0.
REQ-027 SHALL, on that same edge, reset the matrix to row i bit j = 1 iff j < i (WIDTH=4: rows 0..3 = 4'b0000, 4'b0001, 4'b0011, 4'b0111), giving index 0 the highest priority.
REQ-028 SHALL give rst priority over every other event, including a transfer in progress; an aborted transfer causes no matrix update.

Verification
REQ-029 SHALL cover: reset, then v_req=4'b1010 -> next cycle v_grant_q=4'b0010, grant_idx=1, grant_valid=1.
REQ-030 SHALL cover: reset, then v_req=4'b1111 with v_last=4'b1111 and gnt_ready=1 held -> grants 0,1,2,3,0 on every second cycle, with an IDLE cycle between grants.
REQ-031 SHALL cover: after reset, grant to 2 then last beat transferred -> row 2 = 4'b1011 and column 2 all zero.
REQ-032 SHALL cover: requester 0 granted with v_req=4'b0011, three beats, gnt_ready toggling, v_last[0] on the third accepted beat -> requester 1 is not granted until the cycle after the IDLE cycle that follows.
REQ-033 SHALL cover: v_last[k]=1 with gnt_ready=0 for 5 cycles -> grant held and matrix unchanged; the update occurs only on the ready cycle.
REQ-034 SHALL cover: rst asserted mid-BUSY -> next cycle grant_valid=0, v_grant_q=0, matrix equals the reset value.
